// File: rtl/pipe_pkg.sv
// pipe_pkg: shared operand-select encodings and register constants for the pipeline
package pipe_pkg;
    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;
    localparam logic [4:0] REG_ZERO  = 5'd0;
endpackage

// File: rtl/hazard_fwd_unit_md_busy_counter.sv
// md_busy_counter: tracks how long the mult/div unit stays busy after an issue
module md_busy_counter #(
    parameter int CNT_W  = 3,
    parameter int MD_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic issue,
    output logic busy
);
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (issue)
            count <= CNT_W'(MD_LAT);
        else if (count != '0)
            count <= count - 1'b1;
    end

    always_comb busy = count != '0;
endmodule

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: EX operand forwarding, load-use / mult-div stalls, branch flushes
// and a saturating stall-cycle counter for the 5-stage pipeline.
module hazard_fwd_unit
    import pipe_pkg::*;
#(
    parameter int REG_W  = 5,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 3,
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_is_md,
    input  logic              id_reads_hilo,
    input  logic [REG_W-1:0]  ex_rs,
    input  logic [REG_W-1:0]  ex_rt,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic [REG_W-1:0]  mem_rd,
    input  logic              mem_reg_write,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic              wb_reg_write,
    input  logic              ex_branch_taken,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic              idex_flush,
    output logic              ifid_flush,
    output logic              md_busy,
    output logic [PERF_W-1:0] stall_cycles
);
    localparam logic [REG_W-1:0] ZERO = REG_W'(REG_ZERO);

    logic load_use;
    logic md_hold;
    logic stall;
    logic branch;
    logic issue;

    // EX/MEM wins over MEM/WB; r0 is hardwired so it never forwards
    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
        return (mem_reg_write && mem_rd != ZERO && mem_rd == src) ? FWD_EXMEM :
               (wb_reg_write && wb_rd != ZERO && wb_rd == src)    ? FWD_MEMWB : FWD_REG;
    endfunction

    always_comb begin
        load_use   = ex_mem_read && ex_reg_write && ex_rd != ZERO &&
                     ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
        md_hold    = md_busy && (id_is_md || id_reads_hilo);
        branch     = ex_branch_taken && !rst;
        stall      = (load_use || md_hold) && !ex_branch_taken && !rst;
        issue      = id_is_md && !stall && !branch;
        pc_stall   = stall;
        ifid_stall = stall;
        idex_flush = stall || branch;
        ifid_flush = branch;
        fwd_a      = rst ? FWD_REG : fwd_sel(ex_rs);
        fwd_b      = rst ? FWD_REG : fwd_sel(ex_rt);
    end

    md_busy_counter #(.CNT_W(CNT_W), .MD_LAT(MD_LAT)) u_md (
        .clk   (clk),
        .rst   (rst),
        .issue (issue),
        .busy  (md_busy)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cycles <= '0;
        else if (stall && stall_cycles != '1)
            stall_cycles <= stall_cycles + 1'b1;
    end
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: directed scoreboard bench for hazard_fwd_unit (PERF_W=4 to reach saturation)
module tb_hazard_fwd_unit;
    localparam int MD = 4;
    localparam int PW = 4;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic id_uses_rs, id_uses_rt, id_is_md, id_reads_hilo;
    logic ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write, ex_branch_taken;
    logic [1:0] fwd_a, fwd_b;
    logic pc_stall, ifid_stall, idex_flush, ifid_flush, md_busy;
    logic [PW-1:0] stall_cycles;

    int tests = 0;
    int fails = 0;
    int mdc = 0;
    int perf = 0;
    logic [12:0] exp_q[$];

    always #5 clk = ~clk;

    hazard_fwd_unit #(.REG_W(5), .MD_LAT(MD), .CNT_W(3), .PERF_W(PW)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_is_md(id_is_md), .id_reads_hilo(id_reads_hilo),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .ex_branch_taken(ex_branch_taken),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall),
        .idex_flush(idex_flush), .ifid_flush(ifid_flush),
        .md_busy(md_busy), .stall_cycles(stall_cycles)
    );

    task automatic clear();
        {id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd} = '0;
        {id_uses_rs, id_uses_rt, id_is_md, id_reads_hilo} = '0;
        {ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write, ex_branch_taken} = '0;
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] s);
        if (mem_reg_write && mem_rd != 5'd0 && mem_rd == s) return 2'b01;
        if (wb_reg_write && wb_rd != 5'd0 && wb_rd == s) return 2'b10;
        return 2'b00;
    endfunction

    // Model predicts outputs for the current inputs, DUT is sampled 1ns later, then the clock advances
    task automatic step(input string tag);
        logic lu, st, br;
        logic [12:0] e, g;
        if (rst) begin
            mdc = 0;
            perf = 0;
        end
        lu = ex_mem_read && ex_reg_write && ex_rd != 5'd0 &&
             ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
        br = ex_branch_taken && !rst;
        st = (lu || (mdc != 0 && (id_is_md || id_reads_hilo))) && !ex_branch_taken && !rst;
        e = {rst ? 2'b00 : ref_fwd(ex_rs), rst ? 2'b00 : ref_fwd(ex_rt),
             st, st, st || br, br, mdc != 0 && !rst, 4'(perf)};
        exp_q.push_back(e);
        #1;
        g = {fwd_a, fwd_b, pc_stall, ifid_stall, idex_flush, ifid_flush, md_busy, stall_cycles};
        e = exp_q.pop_front();
        tests++;
        assert (g === e) else begin
            fails++;
            $error("FAIL %s got={fa,fb,pcs,ifs,idf,iff,busy,cnt}=%b expected=%b", tag, g, e);
        end
        @(posedge clk);
        if (!rst) begin
            if (id_is_md && !st && !br) mdc = MD;
            else if (mdc > 0) mdc--;
            if (st && perf < (1 << PW) - 1) perf++;
        end
        @(negedge clk);
    endtask

    initial begin
        clear();
        rst = 1'b1;
        @(negedge clk);
        step("reset_state");
        rst = 1'b0;
        step("idle");

        mem_rd = 5'd8; wb_rd = 5'd8; mem_reg_write = 1; wb_reg_write = 1; ex_rs = 5'd8; ex_rt = 5'd8;
        step("fwd_exmem_priority");
        mem_reg_write = 0;
        step("fwd_memwb");
        mem_reg_write = 1; mem_rd = 5'd0; ex_rs = 5'd0; ex_rt = 5'd3; wb_rd = 5'd3;
        step("fwd_r0_and_b_memwb");
        wb_rd = 5'd0; ex_rt = 5'd0; mem_rd = 5'd0;
        step("fwd_r0_both");
        clear();

        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd9; id_rt = 5'd9; id_uses_rt = 1;
        step("load_use_stall");
        clear();
        mem_rd = 5'd9; mem_reg_write = 1; ex_rt = 5'd9;
        step("load_use_released");
        clear();
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd0; id_rs = 5'd0; id_uses_rs = 1;
        step("load_r0_no_stall");
        clear();
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd9; id_rs = 5'd9; id_uses_rs = 1; ex_branch_taken = 1;
        step("branch_overrides_stall");
        clear();
        step("after_branch");

        id_is_md = 1;
        step("md_issue");
        clear();
        step("md_busy_no_dep");
        id_reads_hilo = 1;
        for (int i = 0; i < 4; i++) step($sformatf("mfhi_wait_%0d", i));
        clear();

        id_is_md = 1;
        step("md_issue_2");
        clear();
        step("busy_1");
        step("busy_2");
        rst = 1'b1;
        step("reset_mid_busy");
        rst = 1'b0;
        id_reads_hilo = 1;
        step("hilo_after_reset");
        clear();

        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd12; id_rs = 5'd12; id_uses_rs = 1;
        for (int i = 0; i < 20; i++) step($sformatf("saturate_%0d", i));
        clear();
        step("saturated_hold");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Pipeline hazard controller for the 5-stage MIPS core.
- Drives the 2-bit select inputs of the EX-stage 3:1 operand muxes: fwd_a and fwd_b.
- Drives stall and flush controls for the PC, IF/ID and ID/EX registers.
- Tracks the multi-cycle mult/div (HI/LO) unit with an internal busy counter, and keeps a saturating stall-cycle performance counter.

Parameters:
- REG_W, 5, register-index width.
- MD_LAT, 4, cycles the mult/div unit stays busy after issue (1..7).
- CNT_W, 3, width of the mult/div busy counter; must hold MD_LAT.
- PERF_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs, id_rt  in  REG_W each  source registers of the instruction in ID.
- id_uses_rs, id_uses_rt  in  1 each  ID instruction actually reads rs / rt.
- id_is_md  in  1  ID instruction is mult/multu/div/divu.
- id_reads_hilo  in  1  ID instruction is mfhi/mflo.
- ex_rs, ex_rt  in  REG_W each  source registers of the instruction in EX.
- ex_rd  in  REG_W  destination register of the instruction in EX.
- ex_reg_write, ex_mem_read  in  1 each  EX instruction writes the register file / is a load.
- mem_rd  in  REG_W;  mem_reg_write  in  1  EX/MEM destination and write enable.
- wb_rd  in  REG_W;  wb_reg_write  in  1  MEM/WB destination and write enable.
- ex_branch_taken  in  1  branch or jump resolved taken in EX.
- fwd_a, fwd_b  out  2 each  operand selects: 00 register/ID-EX value, 01 EX/MEM result, 10 MEM/WB writeback value; 11 is never driven.
- pc_stall, ifid_stall  out  1 each  hold the PC / hold IF/ID.
- idex_flush  out  1  load a bubble into ID/EX.
- ifid_flush  out  1  clear IF/ID.
- md_busy  out  1  mult/div unit busy.
- stall_cycles  out  PERF_W  saturating count of stall cycles.

Behaviour:
- Reset (async, rst=1): md counter=0, stall_cycles=0. All stall/flush outputs and md_busy are forced to 0, and fwd_a/fwd_b to 00, while rst is high.
- Forwarding is combinational and computed per operand, shown here for A using ex_rs (B uses ex_rt):
  - 01 if mem_reg_write && mem_rd!=0 && mem_rd==ex_rs.
  - Else 10 if wb_reg_write && wb_rd!=0 && wb_rd==ex_rs.
  - Else 00.
  - EX/MEM has priority over MEM/WB. Register 0 is never forwarded.
- load_use = ex_mem_read && ex_reg_write && ex_rd!=0 && ((id_uses_rs && id_rs==ex_rd) || (id_uses_rt && id_rt==ex_rd)).
- md_hold = md_busy && (id_is_md || id_reads_hilo).
- stall = (load_use || md_hold) && !ex_branch_taken.
  - When stall=1: pc_stall=1, ifid_stall=1, idex_flush=1.
- Branch taken (ex_branch_taken=1): ifid_flush=1, idex_flush=1, pc_stall=0, ifid_stall=0. A taken branch overrides any stall in the same cycle.
- Load-use costs exactly one bubble: the next cycle the load sits in MEM and is forwarded via 10 on the following EX.
- Mult/div counter (registered):
  - Issue = id_is_md && !stall && !ex_branch_taken. On issue the counter loads MD_LAT.
  - Otherwise, if nonzero, it decrements by 1.
  - md_busy = (counter != 0), combinational from the register.
  - Issue while busy is impossible, because md_hold stalls it.
  - MD_LAT=4 → md_busy high for exactly 4 cycles after the issue edge.
  - A dependent mfhi proceeds in the cycle md_busy first reads 0.
- stall_cycles: increments on each clk edge where stall=1 and saturates at all-ones (no wrap). Flush-only cycles are not counted.
- Reset asserted mid-operation clears the counter immediately, with no pending stall. After release, the unit resumes from idle.

Decomposition:
- Shared package `pipe_pkg`:
  - FWD_REG=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10.
  - REG_ZERO=5'd0.
- One sub-module, `md_busy_counter` (CNT_W, MD_LAT): load/decrement counter with busy output.
- Forwarding and stall logic stay in the top module.

Test Plan:
- Forward priority: mem_rd=8, wb_rd=8, both write enables, ex_rs=8 → fwd_a=01. Drop mem_reg_write → fwd_a=10. ex_rs=0 with mem_rd=0 → fwd_a=00.
- Load-use: ex_mem_read=1, ex_rd=9, id_rt=9, id_uses_rt=1 → pc_stall=ifid_stall=idex_flush=1 for exactly 1 cycle, then 0; stall_cycles increments by 1.
- Branch overrides stall: load_use condition true and ex_branch_taken=1 → ifid_flush=idex_flush=1, pc_stall=0; stall_cycles unchanged.
- Mult then mfhi: issue id_is_md=1 (MD_LAT=4), then id_reads_hilo=1 → md_busy high 4 cycles, stall high for 3 of them (the cycle mfhi is in ID while busy); mfhi released when md_busy=0.
- Reset mid-busy: assert rst asynchronously 2 cycles into busy → md_busy=0 and all stalls 0 immediately; after release, id_reads_hilo=1 causes no stall.
- Saturation: PERF_W=4, hold load_use for 20 cycles → stall_cycles stops at 15.
